// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the 2:1 AXI-Lite arbiter.
// Build with AXI_ARB_TIMEOUT_EN to add the ERR state used by the watchdog.
package axi_lite_arbiter_pkg;

   typedef logic [1:0] axi_mst_resp_t;

   localparam axi_mst_resp_t AXI_RESP_OKAY   = 2'b00;
   localparam axi_mst_resp_t AXI_RESP_EXOKAY = 2'b01;
   localparam axi_mst_resp_t AXI_RESP_SLVERR = 2'b10;
   localparam axi_mst_resp_t AXI_RESP_DECERR = 2'b11;

   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   localparam int ST_IDLE_BIT  = 0;
   localparam int ST_RD_AR_BIT = 1;
   localparam int ST_RD_R_BIT  = 2;
   localparam int ST_WR_BIT    = 3;
   localparam int ST_WR_B_BIT  = 4;
   localparam int ST_ERR_BIT   = 5;

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int ARB_ST_W = 6;
`else
   localparam int ARB_ST_W = 5;
`endif

   // One-hot arbiter states; ERR exists only in the watchdog build.
   typedef enum logic [ARB_ST_W-1:0] {
      ST_IDLE    = ARB_ST_W'(1 << ST_IDLE_BIT),
      ST_RD_AR   = ARB_ST_W'(1 << ST_RD_AR_BIT),
      ST_RD_R    = ARB_ST_W'(1 << ST_RD_R_BIT),
      ST_WR_AW_W = ARB_ST_W'(1 << ST_WR_BIT),
      ST_WR_B    = ARB_ST_W'(1 << ST_WR_B_BIT)
`ifdef AXI_ARB_TIMEOUT_EN
      , ST_ERR   = ARB_ST_W'(1 << ST_ERR_BIT)
`endif
   } arb_state_e;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI-Lite bus bundle (AR/R/AW/W/B). The master modport is the side that
// issues requests; the slave modport is the side that answers them.
interface axi_lite_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   import axi_lite_arbiter_pkg::*;

   logic                ar_valid;
   logic [ADDR_W-1:0]   ar_addr;
   logic                ar_ready;
   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   axi_mst_resp_t       r_resp;
   logic                r_ready;
   logic                aw_valid;
   logic [ADDR_W-1:0]   aw_addr;
   logic                aw_ready;
   logic                w_valid;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                w_ready;
   logic                b_valid;
   axi_mst_resp_t       b_resp;
   logic                b_ready;

   modport master (
      output ar_valid, ar_addr, input  ar_ready,
      input  r_valid, r_data, r_resp, output r_ready,
      output aw_valid, aw_addr, input  aw_ready,
      output w_valid, w_data, w_strb, input  w_ready,
      input  b_valid, b_resp, output b_ready
   );

   modport slave (
      input  ar_valid, ar_addr, output ar_ready,
      output r_valid, r_data, r_resp, input  r_ready,
      input  aw_valid, aw_addr, output aw_ready,
      input  w_valid, w_data, w_strb, output w_ready,
      output b_valid, b_resp, input  b_ready
   );

endinterface

// File: rtl/axi_lite_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a tie goes to the master that
// did not win last time.
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       gnt_o,
   output logic       gnt_valid_o
);

   always_comb begin
      gnt_o = 1'b0;
      case (req_i)
         2'b10:   gnt_o = 1'b1;
         2'b11:   gnt_o = ~last_grant_i;
         default: gnt_o = 1'b0;
      endcase
   end

   assign gnt_valid_o = |req_i;

endmodule

// File: rtl/axi_lite_arbiter.sv
// 2:1 AXI-Lite arbiter (m0 = IFU, m1 = LSU) forwarding one transaction at a time.
// Define AXI_ARB_TIMEOUT_EN to add a watchdog that answers SLVERR after TIMEOUT_CYCLES.
module axi_lite_arbiter
   import axi_lite_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef AXI_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
   input  logic clk_i,
   input  logic rst_i,
   axi_lite_arbiter_if.slave  m0_if,
   axi_lite_arbiter_if.slave  m1_if,
   axi_lite_arbiter_if.master s_if
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_e state_q;
   logic       grant_q, lastGrant_q, awDone_q, wDone_q;
   logic       pickGnt, pickValid, pickArValid;

   logic              gArValid, gRReady, gAwValid, gWValid, gBReady;
   logic [ADDR_W-1:0] gArAddr, gAwAddr;
   logic [DATA_W-1:0] gWData;
   logic [STRB_W-1:0] gWStrb;
   logic              arHs, rHs, awHs, wHs, bHs;

   logic              sArValid, sRReady, sAwValid, sWValid, sBReady;
   logic [ADDR_W-1:0] sArAddr, sAwAddr;
   logic [DATA_W-1:0] sWData;
   logic [STRB_W-1:0] sWStrb;
   logic              gArReady, gRValid, gAwReady, gWReady, gBValid;
   logic [DATA_W-1:0] gRData;
   axi_mst_resp_t     gRResp, gBResp;

   rr_arb2 u_rrArb (
      .req_i       ({m1_if.ar_valid | m1_if.aw_valid, m0_if.ar_valid | m0_if.aw_valid}),
      .last_grant_i(lastGrant_q),
      .gnt_o       (pickGnt),
      .gnt_valid_o (pickValid)
   );

   assign pickArValid = pickGnt ? m1_if.ar_valid : m0_if.ar_valid;

   assign gArValid = grant_q ? m1_if.ar_valid : m0_if.ar_valid;
   assign gArAddr  = grant_q ? m1_if.ar_addr  : m0_if.ar_addr;
   assign gRReady  = grant_q ? m1_if.r_ready  : m0_if.r_ready;
   assign gAwValid = grant_q ? m1_if.aw_valid : m0_if.aw_valid;
   assign gAwAddr  = grant_q ? m1_if.aw_addr  : m0_if.aw_addr;
   assign gWValid  = grant_q ? m1_if.w_valid  : m0_if.w_valid;
   assign gWData   = grant_q ? m1_if.w_data   : m0_if.w_data;
   assign gWStrb   = grant_q ? m1_if.w_strb   : m0_if.w_strb;
   assign gBReady  = grant_q ? m1_if.b_ready  : m0_if.b_ready;

   assign arHs = (state_q == ST_RD_AR)   && gArValid && s_if.ar_ready;
   assign rHs  = (state_q == ST_RD_R)    && s_if.r_valid && gRReady;
   assign awHs = (state_q == ST_WR_AW_W) && !awDone_q && gAwValid && s_if.aw_ready;
   assign wHs  = (state_q == ST_WR_AW_W) && !wDone_q && gWValid && s_if.w_ready;
   assign bHs  = (state_q == ST_WR_B)    && s_if.b_valid && gBReady;

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             errIsRead_q;
   logic             timeoutHit, errHs;

   // A final response landing on the expiry cycle still wins over the watchdog.
   assign timeoutHit = (state_q != ST_IDLE) && (state_q != ST_ERR) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !rHs && !bHs;
   assign errHs      = (state_q == ST_ERR) && (errIsRead_q ? gRReady : gBReady);
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         grant_q     <= 1'b0;
         lastGrant_q <= 1'b1;
         awDone_q    <= 1'b0;
         wDone_q     <= 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
         cnt_q       <= '0;
         errIsRead_q <= 1'b0;
`endif
      end else begin
`ifdef AXI_ARB_TIMEOUT_EN
         if (state_q != ST_IDLE) cnt_q <= cnt_q + 1'b1;
`endif
         case (state_q)
            ST_IDLE: begin
               if (pickValid) begin
                  grant_q <= pickGnt;
                  state_q <= pickArValid ? ST_RD_AR : ST_WR_AW_W;
`ifdef AXI_ARB_TIMEOUT_EN
                  cnt_q       <= '0;
                  errIsRead_q <= pickArValid;
`endif
               end
            end
            ST_RD_AR: if (arHs) state_q <= ST_RD_R;
            ST_RD_R: begin
               if (rHs) begin
                  state_q     <= ST_IDLE;
                  lastGrant_q <= grant_q;
               end
            end
            ST_WR_AW_W: begin
               if ((awDone_q || awHs) && (wDone_q || wHs)) begin
                  state_q  <= ST_WR_B;
                  awDone_q <= 1'b0;
                  wDone_q  <= 1'b0;
               end else begin
                  if (awHs) awDone_q <= 1'b1;
                  if (wHs)  wDone_q  <= 1'b1;
               end
            end
            ST_WR_B: begin
               if (bHs) begin
                  state_q     <= ST_IDLE;
                  lastGrant_q <= grant_q;
               end
            end
`ifdef AXI_ARB_TIMEOUT_EN
            ST_ERR: begin
               if (errHs) begin
                  state_q     <= ST_IDLE;
                  lastGrant_q <= grant_q;
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
`ifdef AXI_ARB_TIMEOUT_EN
         if (timeoutHit) begin
            state_q  <= ST_ERR;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
         end
`endif
      end
   end

   // Channel routing is purely a function of state, so IDLE and reset force everything to 0.
   always_comb begin
      sArValid = 1'b0; sArAddr = '0; sRReady = 1'b0;
      sAwValid = 1'b0; sAwAddr = '0;
      sWValid  = 1'b0; sWData  = '0; sWStrb  = '0; sBReady = 1'b0;
      gArReady = 1'b0; gRValid = 1'b0; gRData = '0; gRResp = AXI_RESP_OKAY;
      gAwReady = 1'b0; gWReady = 1'b0; gBValid = 1'b0; gBResp = AXI_RESP_OKAY;
      case (state_q)
         ST_RD_AR: begin
            sArValid = gArValid;
            if (gArValid) sArAddr = gArAddr;
            gArReady = s_if.ar_ready;
         end
         ST_RD_R: begin
            gRValid = s_if.r_valid;
            if (s_if.r_valid) begin
               gRData = s_if.r_data;
               gRResp = s_if.r_resp;
            end
            sRReady = gRReady;
         end
         ST_WR_AW_W: begin
            if (!awDone_q) begin
               sAwValid = gAwValid;
               if (gAwValid) sAwAddr = gAwAddr;
               gAwReady = s_if.aw_ready;
            end
            if (!wDone_q) begin
               sWValid = gWValid;
               if (gWValid) begin
                  sWData = gWData;
                  sWStrb = gWStrb;
               end
               gWReady = s_if.w_ready;
            end
         end
         ST_WR_B: begin
            gBValid = s_if.b_valid;
            if (s_if.b_valid) gBResp = s_if.b_resp;
            sBReady = gBReady;
         end
`ifdef AXI_ARB_TIMEOUT_EN
         ST_ERR: begin
            if (errIsRead_q) begin
               gRValid = 1'b1;
               gRResp  = AXI_RESP_SLVERR;
            end else begin
               gBValid = 1'b1;
               gBResp  = AXI_RESP_SLVERR;
            end
         end
`endif
         default: ;
      endcase
   end

   assign s_if.ar_valid = sArValid;
   assign s_if.ar_addr  = sArAddr;
   assign s_if.r_ready  = sRReady;
   assign s_if.aw_valid = sAwValid;
   assign s_if.aw_addr  = sAwAddr;
   assign s_if.w_valid  = sWValid;
   assign s_if.w_data   = sWData;
   assign s_if.w_strb   = sWStrb;
   assign s_if.b_ready  = sBReady;

   assign m0_if.ar_ready = !grant_q && gArReady;
   assign m0_if.r_valid  = !grant_q && gRValid;
   assign m0_if.r_data   = grant_q ? '0 : gRData;
   assign m0_if.r_resp   = grant_q ? AXI_RESP_OKAY : gRResp;
   assign m0_if.aw_ready = !grant_q && gAwReady;
   assign m0_if.w_ready  = !grant_q && gWReady;
   assign m0_if.b_valid  = !grant_q && gBValid;
   assign m0_if.b_resp   = grant_q ? AXI_RESP_OKAY : gBResp;

   assign m1_if.ar_ready = grant_q && gArReady;
   assign m1_if.r_valid  = grant_q && gRValid;
   assign m1_if.r_data   = grant_q ? gRData : '0;
   assign m1_if.r_resp   = grant_q ? gRResp : AXI_RESP_OKAY;
   assign m1_if.aw_ready = grant_q && gAwReady;
   assign m1_if.w_ready  = grant_q && gWReady;
   assign m1_if.b_valid  = grant_q && gBValid;
   assign m1_if.b_resp   = grant_q ? gBResp : AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter; the watchdog scenario
// is exercised only when AXI_ARB_TIMEOUT_EN is defined.
module tb_axi_lite_arbiter;
   import axi_lite_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rstN;
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   awHsCount   = 0;
   int   wHsCount    = 0;

   axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0Bus ();
   axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1Bus ();
   axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sBus ();

   axi_lite_arbiter #(
      .ADDR_W(32),
      .DATA_W(32)
`ifdef AXI_ARB_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk_i(clk),
      .rst_i(rstN),
      .m0_if(m0Bus),
      .m1_if(m1Bus),
      .s_if (sBus)
   );

   always #5 clk = ~clk;

   // Slave-side handshake counters used by the write scenario.
   always @(posedge clk) begin
      if (sBus.aw_valid && sBus.aw_ready) awHsCount++;
      if (sBus.w_valid && sBus.w_ready)   wHsCount++;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      m0Bus.ar_valid = 0; m0Bus.ar_addr = 0; m0Bus.r_ready = 0;
      m0Bus.aw_valid = 0; m0Bus.aw_addr = 0; m0Bus.w_valid = 0;
      m0Bus.w_data = 0; m0Bus.w_strb = 0; m0Bus.b_ready = 0;
      m1Bus.ar_valid = 0; m1Bus.ar_addr = 0; m1Bus.r_ready = 0;
      m1Bus.aw_valid = 0; m1Bus.aw_addr = 0; m1Bus.w_valid = 0;
      m1Bus.w_data = 0; m1Bus.w_strb = 0; m1Bus.b_ready = 0;
      sBus.ar_ready = 0; sBus.r_valid = 0; sBus.r_data = 0; sBus.r_resp = 0;
      sBus.aw_ready = 0; sBus.w_ready = 0; sBus.b_valid = 0; sBus.b_resp = 0;
   endtask

   task automatic applyStimulus(input bit mst, input bit arValid, input logic [31:0] arAddr,
                                input bit rReady);
      if (mst) begin
         m1Bus.ar_valid = arValid; m1Bus.ar_addr = arAddr; m1Bus.r_ready = rReady;
      end else begin
         m0Bus.ar_valid = arValid; m0Bus.ar_addr = arAddr; m0Bus.r_ready = rReady;
      end
   endtask

   // Full read for one master, entered in IDLE; the other master may hold a pending request.
   task automatic readTxn(input bit mst, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input string tag);
      applyStimulus(mst, 1'b1, addr, 1'b0);
      #1;
      checkOutput({tag, " idle s_ar_valid"}, 64'(sBus.ar_valid), 64'd0);
      tick();
      sBus.ar_ready = 1;
      #1;
      checkOutput({tag, " s_ar_valid"}, 64'(sBus.ar_valid), 64'd1);
      checkOutput({tag, " s_ar_addr"}, 64'(sBus.ar_addr), 64'(addr));
      checkOutput({tag, " gnt ar_ready"}, 64'(mst ? m1Bus.ar_ready : m0Bus.ar_ready), 64'd1);
      checkOutput({tag, " other ar_ready"}, 64'(mst ? m0Bus.ar_ready : m1Bus.ar_ready), 64'd0);
      tick();
      applyStimulus(mst, 1'b0, 32'h0, 1'b1);
      sBus.ar_ready = 0; sBus.r_valid = 1; sBus.r_data = data; sBus.r_resp = resp;
      #1;
      checkOutput({tag, " r_valid"}, 64'(mst ? m1Bus.r_valid : m0Bus.r_valid), 64'd1);
      checkOutput({tag, " r_data"}, 64'(mst ? m1Bus.r_data : m0Bus.r_data), 64'(data));
      checkOutput({tag, " r_resp"}, 64'(mst ? m1Bus.r_resp : m0Bus.r_resp), 64'(resp));
      checkOutput({tag, " other r_valid"}, 64'(mst ? m0Bus.r_valid : m1Bus.r_valid), 64'd0);
      checkOutput({tag, " other r_data"}, 64'(mst ? m0Bus.r_data : m1Bus.r_data), 64'd0);
      checkOutput({tag, " s_r_ready"}, 64'(sBus.r_ready), 64'd1);
      tick();
      applyStimulus(mst, 1'b0, 32'h0, 1'b0);
      sBus.r_valid = 0; sBus.r_data = 0; sBus.r_resp = 0;
      #1;
      checkOutput({tag, " done r_valid"}, 64'(mst ? m1Bus.r_valid : m0Bus.r_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clearInputs();
      rstN = 0;
      // Active inputs during reset must not leak through.
      m0Bus.ar_valid = 1; m0Bus.r_ready = 1; sBus.r_valid = 1; sBus.ar_ready = 1;
      sBus.b_valid = 1; m1Bus.aw_valid = 1; sBus.aw_ready = 1;
      #22;
      checkOutput("rst s valids", 64'({sBus.ar_valid, sBus.aw_valid, sBus.w_valid}), 64'd0);
      checkOutput("rst s readys", 64'({sBus.r_ready, sBus.b_ready}), 64'd0);
      checkOutput("rst s addr", 64'({sBus.ar_addr, sBus.aw_addr}), 64'd0);
      checkOutput("rst m0 outs", 64'({m0Bus.ar_ready, m0Bus.r_valid, m0Bus.aw_ready,
                                      m0Bus.w_ready, m0Bus.b_valid}), 64'd0);
      checkOutput("rst m1 outs", 64'({m1Bus.ar_ready, m1Bus.r_valid, m1Bus.aw_ready,
                                      m1Bus.w_ready, m1Bus.b_valid}), 64'd0);
      clearInputs();
      @(negedge clk);
      rstN = 1;
      tick();

      // Tie right after reset goes to m0, then alternates.
      applyStimulus(1'b1, 1'b1, 32'h8000_0100, 1'b0);
      readTxn(1'b0, 32'h8000_0004, 32'h1111_1111, AXI_RESP_OKAY, "tie1 m0");
      applyStimulus(1'b0, 1'b1, 32'h8000_0008, 1'b0);
      readTxn(1'b1, 32'h8000_0100, 32'h2222_2222, AXI_RESP_OKAY, "tie2 m1");
      applyStimulus(1'b1, 1'b1, 32'h8000_0104, 1'b0);
      readTxn(1'b0, 32'h8000_0008, 32'h3333_3333, AXI_RESP_EXOKAY, "tie3 m0");
      readTxn(1'b1, 32'h8000_0104, 32'h4444_4444, AXI_RESP_OKAY, "tie4 m1");

      readTxn(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, AXI_RESP_OKAY, "m0 rd");

      // m1 write: W arrives two cycles after AW, slave stalls W for one cycle.
      awHsCount = 0; wHsCount = 0;
      m1Bus.aw_valid = 1; m1Bus.aw_addr = 32'h8000_0010; sBus.aw_ready = 1;
      #1;
      checkOutput("wr idle s_aw_valid", 64'(sBus.aw_valid), 64'd0);
      tick();
      checkOutput("wr s_aw_valid", 64'(sBus.aw_valid), 64'd1);
      checkOutput("wr s_aw_addr", 64'(sBus.aw_addr), 64'h8000_0010);
      checkOutput("wr m1 aw_ready", 64'(m1Bus.aw_ready), 64'd1);
      checkOutput("wr m0 aw_ready", 64'(m0Bus.aw_ready), 64'd0);
      checkOutput("wr early s_w_valid", 64'(sBus.w_valid), 64'd0);
      tick();
      m1Bus.w_valid = 1; m1Bus.w_data = 32'h1234_5678; m1Bus.w_strb = 4'b0011;
      #1;
      checkOutput("wr aw masked", 64'(sBus.aw_valid), 64'd0);
      checkOutput("wr aw_ready masked", 64'(m1Bus.aw_ready), 64'd0);
      checkOutput("wr s_w_valid", 64'(sBus.w_valid), 64'd1);
      checkOutput("wr s_w_data", 64'(sBus.w_data), 64'h1234_5678);
      checkOutput("wr s_w_strb", 64'(sBus.w_strb), 64'h3);
      checkOutput("wr w stalled", 64'(m1Bus.w_ready), 64'd0);
      tick();
      sBus.w_ready = 1;
      #1;
      checkOutput("wr m1 w_ready", 64'(m1Bus.w_ready), 64'd1);
      tick();
      m1Bus.aw_valid = 0; m1Bus.w_valid = 0; sBus.w_ready = 0; sBus.aw_ready = 0;
      sBus.b_valid = 1; sBus.b_resp = AXI_RESP_OKAY; m1Bus.b_ready = 1;
      #1;
      checkOutput("wr m1 b_valid", 64'(m1Bus.b_valid), 64'd1);
      checkOutput("wr m1 b_resp", 64'(m1Bus.b_resp), 64'(AXI_RESP_OKAY));
      checkOutput("wr m0 b_valid", 64'(m0Bus.b_valid), 64'd0);
      checkOutput("wr s_b_ready", 64'(sBus.b_ready), 64'd1);
      tick();
      sBus.b_valid = 0; m1Bus.b_ready = 0;
      #1;
      checkOutput("wr done b_valid", 64'(m1Bus.b_valid), 64'd0);
      checkOutput("wr aw handshakes", 64'(awHsCount), 64'd1);
      checkOutput("wr w handshakes", 64'(wHsCount), 64'd1);

      // m1 AR and AW together: read first, write after one IDLE cycle.
      m1Bus.ar_valid = 1; m1Bus.ar_addr = 32'h8000_0020;
      m1Bus.aw_valid = 1; m1Bus.aw_addr = 32'h8000_0024;
      m1Bus.w_valid = 1; m1Bus.w_data = 32'hCAFE_F00D; m1Bus.w_strb = 4'hF;
      sBus.ar_ready = 1; sBus.aw_ready = 1; sBus.w_ready = 1;
      tick();
      checkOutput("rw s_ar_valid", 64'(sBus.ar_valid), 64'd1);
      checkOutput("rw aw held", 64'({sBus.aw_valid, sBus.w_valid}), 64'd0);
      tick();
      m1Bus.ar_valid = 0; sBus.ar_ready = 0;
      sBus.r_valid = 1; sBus.r_data = 32'h0BAD_F00D; sBus.r_resp = AXI_RESP_DECERR;
      m1Bus.r_ready = 1;
      #1;
      checkOutput("rw r_resp decerr", 64'(m1Bus.r_resp), 64'(AXI_RESP_DECERR));
      checkOutput("rw r_data", 64'(m1Bus.r_data), 64'h0BAD_F00D);
      checkOutput("rw aw during r", 64'(sBus.aw_valid), 64'd0);
      tick();
      sBus.r_valid = 0; sBus.r_data = 0; sBus.r_resp = 0; m1Bus.r_ready = 0;
      #1;
      checkOutput("rw idle aw", 64'(sBus.aw_valid), 64'd0);
      tick();
      checkOutput("rw s_aw_valid", 64'(sBus.aw_valid), 64'd1);
      checkOutput("rw s_aw_addr", 64'(sBus.aw_addr), 64'h8000_0024);
      checkOutput("rw same-cycle readys", 64'({m1Bus.aw_ready, m1Bus.w_ready}), 64'h3);
      tick();
      m1Bus.aw_valid = 0; m1Bus.w_valid = 0; sBus.aw_ready = 0; sBus.w_ready = 0;
      sBus.b_valid = 1; sBus.b_resp = AXI_RESP_SLVERR; m1Bus.b_ready = 1;
      #1;
      checkOutput("rw b_valid", 64'(m1Bus.b_valid), 64'd1);
      checkOutput("rw b_resp slverr", 64'(m1Bus.b_resp), 64'(AXI_RESP_SLVERR));
      tick();
      sBus.b_valid = 0; sBus.b_resp = 0; m1Bus.b_ready = 0;

      // Reset mid-read: m0 last served, so only the reset makes m0 win the next tie.
      readTxn(1'b0, 32'h8000_0030, 32'h5555_5555, AXI_RESP_OKAY, "pre-rst m0");
      applyStimulus(1'b0, 1'b1, 32'h8000_0040, 1'b0);
      tick();
      sBus.ar_ready = 1;
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      sBus.ar_ready = 0; sBus.r_valid = 1; sBus.r_data = 32'h6666_6666;
      #1;
      checkOutput("mid r_valid", 64'(m0Bus.r_valid), 64'd1);
      rstN = 0;
      #1;
      checkOutput("async rst r_valid", 64'(m0Bus.r_valid), 64'd0);
      checkOutput("async rst r_data", 64'(m0Bus.r_data), 64'd0);
      checkOutput("async rst s_r_ready", 64'(sBus.r_ready), 64'd0);
      clearInputs();
      @(negedge clk);
      rstN = 1;
      tick();
      applyStimulus(1'b1, 1'b1, 32'h8000_0200, 1'b0);
      readTxn(1'b0, 32'h8000_0050, 32'h7777_7777, AXI_RESP_OKAY, "post-rst m0");
      readTxn(1'b1, 32'h8000_0200, 32'h8888_8888, AXI_RESP_OKAY, "post-rst m1");

`ifdef AXI_ARB_TIMEOUT_EN
      // Slave accepts AR but never answers: ERR after 16 non-IDLE cycles.
      applyStimulus(1'b0, 1'b1, 32'h8000_0060, 1'b0);
      sBus.ar_ready = 1;
      tick();
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      sBus.ar_ready = 0;
      for (int i = 0; i < 14; i++) tick();
      checkOutput("to before expiry", 64'(m0Bus.r_valid), 64'd0);
      tick();
      checkOutput("to r_valid", 64'(m0Bus.r_valid), 64'd1);
      checkOutput("to r_resp", 64'(m0Bus.r_resp), 64'(AXI_RESP_SLVERR));
      checkOutput("to r_data", 64'(m0Bus.r_data), 64'd0);
      checkOutput("to s quiet", 64'({sBus.ar_valid, sBus.r_ready}), 64'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("to cleared", 64'(m0Bus.r_valid), 64'd0);
      readTxn(1'b0, 32'h8000_0070, 32'h9999_9999, AXI_RESP_OKAY, "post-to m0");
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
